trace_tx: RTL and testbench

//   Hardware trace transmitter for the monocycle core. Captures one record per retired instruction
//   (pc, instruction, ALU result, control flags) and buffers it in a FIFO.

---
 rtl/trace_pkg.sv | 46 ++++
 rtl/trace_fifo.sv | 64 ++++++
 rtl/trace_tx.sv | 139 +++++++++++++
 tb/tb_trace_tx.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, flag positions and state encoding for trace_tx
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a 16-bit cycle stamp to each record)
package trace_pkg;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W        = 16;
    localparam int FRAME_BYTES = 16;
`else
    localparam int TS_W        = 0;
    localparam int FRAME_BYTES = 14;
`endif

    localparam int REC_W = 104 + TS_W;
    localparam int IDX_W = $clog2(FRAME_BYTES);

    localparam int FLG_RW    = 7;
    localparam int FLG_MW    = 6;
    localparam int FLG_Z     = 5;
    localparam int FLG_BR    = 4;
    localparam int FLG_RS_HI = 3;
    localparam int FLG_RS_LO = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } tx_state_e;

    function automatic logic [7:0] make_flags(
        input logic       rw,
        input logic       mw,
        input logic       z,
        input logic       br,
        input logic [1:0] rs
    );
        logic [7:0] f;
        f                      = 8'h00;
        f[FLG_RW]              = rw;
        f[FLG_MW]              = mw;
        f[FLG_Z]               = z;
        f[FLG_BR]              = br;
        f[FLG_RS_HI:FLG_RS_LO] = rs;
        return f;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous record FIFO with wrap-bit pointers and a registered head
// The head register always holds the oldest entry, so the reader peeks without popping.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int REC_W = 104
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [REC_W-1:0] wdata,
    input  logic             pop,
    output logic             accepted,
    output logic [REC_W-1:0] head,
    output logic             empty,
    output logic             empty_nx
);
    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nx;
    logic [AW:0]      rd_ptr_nx;
    logic             full;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign accepted = push && (!full || do_pop);

    assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, accepted};
    assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, do_pop};
    assign empty_nx  = (wr_ptr_nx == rd_ptr_nx);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // When the new head slot is the one being written this cycle, bypass the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
        end else if (accepted && (wr_ptr == rd_ptr_nx)) begin
            head <= wdata;
        end else begin
            head <= mem[rd_ptr_nx[AW-1:0]];
        end
    end

endmodule

// File: rtl/trace_tx.sv
// rtl/trace_tx.sv - retire-trace capture FIFO and byte-frame serializer on a valid/ready stream
// Optional feature macro: TRACE_TIMESTAMP_EN (16-bit cycle stamp sent after the sync byte)
module trace_tx
    import trace_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_en,
    input  logic        retire,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic [31:0] result,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        zero,
    input  logic        branch_ctrl,
    input  logic [1:0]  reg_src,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] drop_cnt,
    output logic        busy
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 2);

    tx_state_e        state;
    tx_state_e        state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic             capture;
    logic             accepted;
    logic             pop;
    logic             empty;
    logic             empty_nx;
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] head;
    logic [REC_W-1:0] head_sh;

    assign capture = retire && trace_en;

    // Body bytes are the record's bytes lowest first, so the packing order sets the wire order.
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= 16'h0000;
        end else begin
            ts <= ts + 16'h0001;
        end
    end

    assign rec = {make_flags(reg_write, mem_write, zero, branch_ctrl, reg_src),
                  result, instruction, pc, ts};
`else
    assign rec = {make_flags(reg_write, mem_write, zero, branch_ctrl, reg_src),
                  result, instruction, pc};
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (capture),
        .wdata    (rec),
        .pop      (pop),
        .accepted (accepted),
        .head     (head),
        .empty    (empty),
        .empty_nx (empty_nx)
    );

    assign pop     = (state == BODY) && tx_ready && (idx == LAST_IDX);
    assign head_sh = head >> {idx, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // tx_valid comes from state alone; tx_ready only steers the next state.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_nx = BODY;
                    idx_nx   = '0;
                end
            end
            BODY: begin
                tx_valid = 1'b1;
                tx_data  = head_sh[7:0];
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
                        idx_nx   = '0;
                        state_nx = empty_nx ? IDLE : HDR;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 16'h0000;
        end else if (capture && !accepted && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end

    assign busy = !empty || (state != IDLE);

endmodule

// File: tb/tb_trace_tx.sv
// tb/tb_trace_tx.sv - randomized scenario bench for trace_tx against a record-level reference model
module tb_trace_tx;
    import trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int FB    = FRAME_BYTES;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instruction = '0;
    logic [31:0] result = '0;
    logic        reg_write = 1'b0;
    logic        mem_write = 1'b0;
    logic        zero = 1'b0;
    logic        branch_ctrl = 1'b0;
    logic [1:0]  reg_src = 2'b00;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] drop_cnt;
    logic        busy;

    trace_tx #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_en    (trace_en),
        .retire      (retire),
        .pc          (pc),
        .instruction (instruction),
        .result      (result),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .zero        (zero),
        .branch_ctrl (branch_ctrl),
        .reg_src     (reg_src),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] res;
        logic [7:0]  flg;
        logic [15:0] ts;
    } rec_t;

    rec_t       acc_q[$];
    logic [7:0] rx_q[$];
    int         occ;
    int         mdrop;
    int         fpos;
    int         total = 0;
    int         bad = 0;
    logic [15:0] cyc = 16'h0000;

    always @(posedge clk) cyc <= reset ? 16'h0000 : cyc + 16'h0001;

    function automatic logic [7:0] frame_byte(input rec_t r, input int k);
        logic [7:0] b [FB];
        int n;
        b[0] = 8'hA5;
        n = 1;
`ifdef TRACE_TIMESTAMP_EN
        b[1] = r.ts[7:0];
        b[2] = r.ts[15:8];
        n = 3;
`endif
        for (int i = 0; i < 4; i++) begin
            b[n + i]     = 8'(r.pc  >> (8 * i));
            b[n + 4 + i] = 8'(r.ins >> (8 * i));
            b[n + 8 + i] = 8'(r.res >> (8 * i));
        end
        b[n + 12] = r.flg;
        return b[k];
    endfunction

    // Advance one clock while tracking handshakes, captures, drops and pops in the model.
    task automatic step();
        logic hs;
        logic popn;
        rec_t r;
        #1;
        if (reset) begin
            acc_q.delete();
            rx_q.delete();
            occ = 0;
            mdrop = 0;
            fpos = 0;
        end else begin
            hs   = tx_valid && tx_ready;
            popn = hs && (fpos == FB - 1);
            if (hs) begin
                rx_q.push_back(tx_data);
                fpos = popn ? 0 : fpos + 1;
            end
            if (retire && trace_en) begin
                if (occ == DEPTH && !popn) begin
                    if (mdrop < 65535) mdrop++;
                end else begin
                    r.pc  = pc;
                    r.ins = instruction;
                    r.res = result;
                    r.flg = 8'((reg_write ? 128 : 0) + (mem_write ? 64 : 0) + (zero ? 32 : 0)
                               + (branch_ctrl ? 16 : 0) + reg_src * 4);
                    r.ts  = cyc;
                    acc_q.push_back(r);
                    occ++;
                end
            end
            if (popn) occ--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_fields();
        pc          = $urandom;
        instruction = $urandom;
        result      = $urandom;
        reg_write   = 1'($urandom);
        mem_write   = 1'($urandom);
        zero        = 1'($urandom);
        branch_ctrl = 1'($urandom);
        reg_src     = 2'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        retire = 1'b0;
        trace_en = 1'b1;
        tx_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        retire = 1'b0;
        tx_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && fpos == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", tx_data); end
        total++; if (drop_cnt !== 16'h0000) begin bad++; $display("FAIL rst_drop got=%h want=0000", drop_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    endtask

    task automatic test_single();
        logic [7:0] want [FB];
        bit ok;
`ifdef TRACE_TIMESTAMP_EN
        rec_t r;
`else
        logic [7:0] lit [14];
        lit = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h05, 8'h00, 8'h00, 8'h00, 8'h84};
`endif
        do_reset();
        tx_ready = 1'b1;
        pc = 32'h0000_0004; instruction = 32'h0050_0093; result = 32'd5;
        reg_write = 1'b1; mem_write = 1'b0; zero = 1'b0; branch_ctrl = 1'b0; reg_src = 2'b01;
        retire = 1'b1;
        step();
        retire = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b want=0", tx_valid); end
        step();
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            bad++; $display("FAIL t1_first_byte got=%b/%h want=1/a5", tx_valid, tx_data);
        end
        drain(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL t1_drain busy=%b want=0", busy); end
`ifdef TRACE_TIMESTAMP_EN
        r = acc_q[0];
        for (int k = 0; k < FB; k++) want[k] = frame_byte(r, k);
`else
        for (int k = 0; k < FB; k++) want[k] = lit[k];
`endif
        total++; if (rx_q.size() !== FB) begin
            bad++; $display("FAIL t1_len got=%0d want=%0d", rx_q.size(), FB);
        end else begin
            for (int k = 0; k < FB; k++) begin
                total++; if (rx_q[k] !== want[k]) begin
                    bad++; $display("FAIL t1_byte%0d got=%h want=%h", k, rx_q[k], want[k]);
                end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy got=%b want=0", busy); end
    endtask

    task automatic test_overflow();
        bit ok;
        int first_bad;
        do_reset();
        tx_ready = 1'b0;
        retire = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            step();
        end
        retire = 1'b0;
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL t2_drop got=%0d want=2", drop_cnt); end
        drain(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL t2_drain busy=%b want=0", busy); end
        total++; if (rx_q.size() !== 8 * FB) begin
            bad++; $display("FAIL t2_len got=%0d want=%0d", rx_q.size(), 8 * FB);
        end else begin
            for (int i = 0; i < acc_q.size(); i++) begin
                first_bad = -1;
                for (int k = FB - 1; k >= 0; k--) if (rx_q[i * FB + k] !== frame_byte(acc_q[i], k)) first_bad = k;
                total++; if (first_bad >= 0) begin
                    bad++; $display("FAIL t2_frame%0d byte%0d got=%h want=%h", i, first_bad,
                                    rx_q[i * FB + first_bad], frame_byte(acc_q[i], first_bad));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit pv;
        bit pr;
        logic [7:0] pd;
        int first_bad;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rand_fields();
            retire   = ($urandom_range(0, 99) < 45);
            trace_en = ($urandom_range(0, 99) < 90);
            tx_ready = ($urandom_range(0, 99) >= 30);
            #1;
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            step();
            if (pv && !pr) begin
                total++; if (tx_valid !== 1'b1 || tx_data !== pd) begin
                    bad++; $display("FAIL t3_hold cyc%0d got=%b/%h want=1/%h", c, tx_valid, tx_data, pd);
                end
            end
        end
        trace_en = 1'b1;
        drain(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_drain busy=%b want=0", busy); end
        total++; if (drop_cnt !== 16'(mdrop)) begin bad++; $display("FAIL t3_drop got=%0d want=%0d", drop_cnt, mdrop); end
        total++; if (rx_q.size() !== acc_q.size() * FB) begin
            bad++; $display("FAIL t3_len got=%0d want=%0d", rx_q.size(), acc_q.size() * FB);
        end else begin
            for (int i = 0; i < acc_q.size(); i++) begin
                first_bad = -1;
                for (int k = FB - 1; k >= 0; k--) if (rx_q[i * FB + k] !== frame_byte(acc_q[i], k)) first_bad = k;
                total++; if (first_bad >= 0) begin
                    bad++; $display("FAIL t3_frame%0d byte%0d got=%h want=%h", i, first_bad,
                                    rx_q[i * FB + first_bad], frame_byte(acc_q[i], first_bad));
                end
            end
        end
    endtask

    task automatic test_full_pop_push();
        bit ok;
        int first_bad;
        logic [15:0] d0;
        do_reset();
        tx_ready = 1'b0;
        retire = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rand_fields();
            step();
        end
        retire = 1'b0;
        tx_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (fpos == FB - 1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        total++; if (!ok) begin bad++; $display("FAIL t4_reach_last fpos=%0d want=%0d", fpos, FB - 1); end
        d0 = drop_cnt;
        rand_fields();
        retire = 1'b1;
        step();
        retire = 1'b0;
        total++; if (drop_cnt !== d0) begin bad++; $display("FAIL t4_drop got=%0d want=%0d", drop_cnt, d0); end
        drain(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL t4_drain busy=%b want=0", busy); end
        total++; if (rx_q.size() !== (DEPTH + 1) * FB) begin
            bad++; $display("FAIL t4_len got=%0d want=%0d", rx_q.size(), (DEPTH + 1) * FB);
        end else begin
            for (int i = 0; i < acc_q.size(); i++) begin
                first_bad = -1;
                for (int k = FB - 1; k >= 0; k--) if (rx_q[i * FB + k] !== frame_byte(acc_q[i], k)) first_bad = k;
                total++; if (first_bad >= 0) begin
                    bad++; $display("FAIL t4_frame%0d byte%0d got=%h want=%h", i, first_bad,
                                    rx_q[i * FB + first_bad], frame_byte(acc_q[i], first_bad));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int first_bad;
        do_reset();
        tx_ready = 1'b1;
        rand_fields();
        retire = 1'b1;
        step();
        retire = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fpos == 6) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        total++; if (!ok) begin bad++; $display("FAIL t5_reach_byte6 fpos=%0d want=6", fpos); end
        reset = 1'b1;
        step();
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL t5_after_reset got=%b/%b want=0/0", tx_valid, busy);
        end
        reset = 1'b0;
        rand_fields();
        retire = 1'b1;
        step();
        retire = 1'b0;
        drain(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_drain busy=%b want=0", busy); end
        total++; if (rx_q.size() !== FB || acc_q.size() != 1) begin
            bad++; $display("FAIL t5_len got=%0d want=%0d", rx_q.size(), FB);
        end else begin
            total++; if (rx_q[0] !== 8'hA5) begin bad++; $display("FAIL t5_sync got=%h want=a5", rx_q[0]); end
            first_bad = -1;
            for (int k = FB - 1; k >= 0; k--) if (rx_q[k] !== frame_byte(acc_q[0], k)) first_bad = k;
            total++; if (first_bad >= 0) begin
                bad++; $display("FAIL t5_frame byte%0d got=%h want=%h", first_bad, rx_q[first_bad],
                                frame_byte(acc_q[0], first_bad));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_backpressure();
        test_full_pop_push();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
